// File: rtl/snn_load_tx.sv
// Host-side transmitter for the SNN_NoC load protocol: sends load_start, filter words, then per-timestep ifmap words.
// Optional macro SNN_LOAD_TX_ACK_SYNC_EN adds 2-flop synchronizers on every inbound ack/req.
module snn_load_tx #(
   parameter int FILT_N = 25,
   parameter int IFM_N  = 625,
   parameter int NUM_TS = 10,
   parameter int AW     = 10,
   parameter int DW     = 8,
   parameter int MAW    = 14
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           go,
   output logic           busy,
   output logic           run_done,
   output logic           mem_rd,
   output logic [MAW-1:0] mem_addr,
   input  logic [DW-1:0]  mem_rdata,
   output logic           ls_req,
   input  logic           ls_ack,
   output logic [AW-1:0]  fa_data,
   output logic           fa_req,
   input  logic           fa_ack,
   output logic [DW-1:0]  fd_data,
   output logic           fd_req,
   input  logic           fd_ack,
   output logic [3:0]     ts_data,
   output logic           ts_req,
   input  logic           ts_ack,
   output logic [AW-1:0]  ia_data,
   output logic           ia_req,
   input  logic           ia_ack,
   output logic [DW-1:0]  id_data,
   output logic           id_req,
   input  logic           id_ack,
   input  logic           ld_req,
   output logic           ld_ack
);

   localparam int IW = $clog2(FILT_N + 1);
   localparam int JW = $clog2(IFM_N + 1);
   localparam int TW = $clog2(NUM_TS + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LS_SEND, S_F_FETCH, S_F_CAP, S_F_SEND, S_TS_SEND,
      S_I_FETCH, S_I_CAP, S_I_SEND, S_LD_WAIT, S_DONE
   } state_t;

   // Per-channel handshake progress: ARM waits for ack low, REQ holds req, REL waits for ack low again.
   typedef enum logic [1:0] {PH_ARM, PH_REQ, PH_REL, PH_FIN} phase_t;

   state_t         state, state_n;
   phase_t         pa, pa_n, pb, pb_n;
   logic [IW-1:0]  i_q, i_n;
   logic [JW-1:0]  j_q, j_n;
   logic [TW-1:0]  t_q, t_n;
   logic [MAW-1:0] addr_q, addr_n;
   logic           ack_a, ack_b, pair, send_st, tok_done;

   logic [6:0] in_raw, in_s;
   assign in_raw = {ld_req, id_ack, ia_ack, ts_ack, fd_ack, fa_ack, ls_ack};

`ifdef SNN_LOAD_TX_ACK_SYNC_EN
   logic [6:0] sync1, sync2;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_raw;
         sync2 <= sync1;
      end
   end
   assign in_s = sync2;
`else
   assign in_s = in_raw;
`endif

   assign mem_addr = addr_q;

   always_comb begin
      state_n  = state;
      pa_n     = pa;
      pb_n     = pb;
      i_n      = i_q;
      j_n      = j_q;
      t_n      = t_q;
      addr_n   = addr_q;
      ack_a    = 1'b0;
      ack_b    = 1'b0;
      pair     = 1'b0;
      tok_done = 1'b0;
      case (state)
         S_LS_SEND: ack_a = in_s[0];
         S_F_SEND: begin
            ack_a = in_s[1];
            ack_b = in_s[2];
            pair  = 1'b1;
         end
         S_TS_SEND: ack_a = in_s[3];
         S_I_SEND: begin
            ack_a = in_s[4];
            ack_b = in_s[5];
            pair  = 1'b1;
         end
         default: ;
      endcase
      send_st = (state == S_LS_SEND) || (state == S_F_SEND) ||
                (state == S_TS_SEND) || (state == S_I_SEND);

      if (send_st) begin
         if (pa == PH_ARM) begin
            // Both reqs of a pair rise together, and only once every ack is seen low.
            if (!ack_a && !(pair && ack_b)) begin
               pa_n = PH_REQ;
               pb_n = pair ? PH_REQ : PH_FIN;
            end
         end else begin
            if (pa == PH_REQ && ack_a)  pa_n = PH_REL;
            if (pa == PH_REL && !ack_a) pa_n = PH_FIN;
            if (pb == PH_REQ && ack_b)  pb_n = PH_REL;
            if (pb == PH_REL && !ack_b) pb_n = PH_FIN;
         end
         tok_done = (pa == PH_FIN) && (pb == PH_FIN);
         if (tok_done) begin
            pa_n = PH_ARM;
            pb_n = PH_ARM;
         end
      end

      case (state)
         S_IDLE: begin
            if (go) begin
               state_n = S_LS_SEND;
               i_n     = '0;
               j_n     = '0;
               t_n     = '0;
               addr_n  = '0;
            end
         end
         S_LS_SEND: if (tok_done) begin
            state_n = S_F_FETCH;
            i_n     = '0;
         end
         S_F_FETCH: begin
            state_n = S_F_CAP;
            addr_n  = addr_q + MAW'(1);
         end
         S_F_CAP: state_n = S_F_SEND;
         S_F_SEND: if (tok_done) begin
            if (32'(i_q) + 1 < FILT_N) begin
               i_n     = i_q + IW'(1);
               state_n = S_F_FETCH;
            end else begin
               t_n     = '0;
               state_n = S_TS_SEND;
            end
         end
         S_TS_SEND: if (tok_done) begin
            j_n     = '0;
            state_n = S_I_FETCH;
         end
         S_I_FETCH: begin
            state_n = S_I_CAP;
            addr_n  = addr_q + MAW'(1);
         end
         S_I_CAP: state_n = S_I_SEND;
         S_I_SEND: if (tok_done) begin
            if (32'(j_q) + 1 < IFM_N) begin
               j_n     = j_q + JW'(1);
               state_n = S_I_FETCH;
            end else begin
               state_n = S_LD_WAIT;
            end
         end
         S_LD_WAIT: begin
            // Receiver side: ack follows req, completion on the falling req.
            if (pa == PH_ARM && in_s[6]) begin
               pa_n = PH_REQ;
            end else if (pa == PH_REQ && !in_s[6]) begin
               pa_n = PH_ARM;
               pb_n = PH_ARM;
               if (32'(t_q) + 1 < NUM_TS) begin
                  t_n     = t_q + TW'(1);
                  state_n = S_TS_SEND;
               end else begin
                  state_n = S_DONE;
               end
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         pa       <= PH_ARM;
         pb       <= PH_ARM;
         i_q      <= '0;
         j_q      <= '0;
         t_q      <= '0;
         addr_q   <= '0;
         busy     <= 1'b0;
         run_done <= 1'b0;
         mem_rd   <= 1'b0;
         ls_req   <= 1'b0;
         fa_req   <= 1'b0;
         fd_req   <= 1'b0;
         ts_req   <= 1'b0;
         ia_req   <= 1'b0;
         id_req   <= 1'b0;
         ld_ack   <= 1'b0;
         fa_data  <= '0;
         fd_data  <= '0;
         ts_data  <= '0;
         ia_data  <= '0;
         id_data  <= '0;
      end else begin
         state    <= state_n;
         pa       <= pa_n;
         pb       <= pb_n;
         i_q      <= i_n;
         j_q      <= j_n;
         t_q      <= t_n;
         addr_q   <= addr_n;
         busy     <= (state_n != S_IDLE) && (state_n != S_DONE);
         run_done <= (state_n == S_DONE);
         mem_rd   <= (state_n == S_F_FETCH) || (state_n == S_I_FETCH);
         ls_req   <= (state_n == S_LS_SEND) && (pa_n == PH_REQ);
         fa_req   <= (state_n == S_F_SEND)  && (pa_n == PH_REQ);
         fd_req   <= (state_n == S_F_SEND)  && (pb_n == PH_REQ);
         ts_req   <= (state_n == S_TS_SEND) && (pa_n == PH_REQ);
         ia_req   <= (state_n == S_I_SEND)  && (pa_n == PH_REQ);
         id_req   <= (state_n == S_I_SEND)  && (pb_n == PH_REQ);
         ld_ack   <= (state_n == S_LD_WAIT) && (pa_n == PH_REQ);
         // Data lands one cycle before the earliest possible req rise and holds through the token.
         if (state == S_F_CAP) begin
            fa_data <= AW'(i_q);
            fd_data <= mem_rdata;
         end
         if (state == S_I_CAP) begin
            ia_data <= AW'(j_q);
            id_data <= DW'(mem_rdata[0]);
         end
         if (state_n == S_TS_SEND && state != S_TS_SEND) ts_data <= 4'(t_n);
      end
   end

endmodule

// File: tb/tb_snn_load_tx.sv
// Directed bench for snn_load_tx with FILT_N=2, IFM_N=3, NUM_TS=2 and auto-responding 4-phase peers.
module tb_snn_load_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        go = 1'b0;
   logic        busy, run_done, mem_rd;
   logic [13:0] mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic        ls_req, fa_req, fd_req, ts_req, ia_req, id_req;
   logic [9:0]  fa_data, ia_data;
   logic [7:0]  fd_data, id_data;
   logic [3:0]  ts_data;
   logic        ld_req = 1'b0;
   logic        ld_ack;
   logic [5:0]  acks = 6'b0;
   logic [5:0]  reqs;

   logic [7:0]  mem [16];
   int          dly [6];
   int          cnt [6];
   logic        ld_auto = 1'b1;
   logic        ld_man = 1'b0;

   logic [31:0] obs_q[$];
   logic [31:0] exp_q[$];
   int checks = 0, errors = 0;
   int pair_err = 0, stab_err = 0, fetch_err = 0, ld_err = 0, fa_early = 0, done_cnt = 0, ifm_cnt = 0;

   always #5 clk = ~clk;

   assign reqs = {id_req, ia_req, ts_req, fd_req, fa_req, ls_req};

   snn_load_tx #(.FILT_N(2), .IFM_N(3), .NUM_TS(2), .AW(10), .DW(8), .MAW(14)) dut (
      .clk(clk), .reset(reset), .go(go), .busy(busy), .run_done(run_done),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .ls_req(ls_req), .ls_ack(acks[0]),
      .fa_data(fa_data), .fa_req(fa_req), .fa_ack(acks[1]),
      .fd_data(fd_data), .fd_req(fd_req), .fd_ack(acks[2]),
      .ts_data(ts_data), .ts_req(ts_req), .ts_ack(acks[3]),
      .ia_data(ia_data), .ia_req(ia_req), .ia_ack(acks[4]),
      .id_data(id_data), .id_req(id_req), .id_ack(acks[5]),
      .ld_req(ld_req), .ld_ack(ld_ack)
   );

   // Synchronous source memory: one-cycle read latency.
   always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[3:0]];

   // Peers respond on the falling edge so the DUT sees stable inputs.
   always @(negedge clk) begin
      for (int c = 0; c < 6; c++) begin
         if (reset) begin
            acks[c] = 1'b0;
            cnt[c]  = 0;
         end else if (reqs[c] && !acks[c]) begin
            if (cnt[c] >= dly[c]) begin
               acks[c] = 1'b1;
               cnt[c]  = 0;
            end else begin
               cnt[c]++;
            end
         end else if (!reqs[c] && acks[c]) begin
            acks[c] = 1'b0;
         end
      end
      if (reset) ld_req = 1'b0;
      else       ld_req = ld_auto ? !ld_ack : ld_man;
   end

   // Monitor: logs tokens as {type, addr, data} and flags protocol violations.
   logic       p_ls = 0, p_fa = 0, p_fd = 0, p_ts = 0, p_ia = 0, p_id = 0, p_ld = 0;
   logic [9:0] p_fad = 0, p_iad = 0;
   logic [7:0] p_fdd = 0, p_idd = 0;
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         if (ls_req && !p_ls) obs_q.push_back(32'h0100_0000);
         if (fa_req && !p_fa) begin
            obs_q.push_back({8'h02, 6'h00, fa_data, fd_data});
            if (!(fd_req && !p_fd)) pair_err++;
         end
         if (ts_req && !p_ts) begin
            obs_q.push_back({8'h03, 20'h0, ts_data});
            ifm_cnt = 0;
         end
         if (ia_req && !p_ia) begin
            obs_q.push_back({8'h04, 6'h00, ia_data, id_data});
            ifm_cnt++;
            if (!(id_req && !p_id)) pair_err++;
         end
         if (ld_ack && !p_ld && (ifm_cnt != 3 || ia_req || id_req || acks[4] || acks[5])) ld_err++;
         if (!ld_ack && p_ld) obs_q.push_back(32'h0500_0000);
         if (run_done) begin
            obs_q.push_back(32'h0600_0000);
            done_cnt++;
         end
         if ((fa_req && p_fa && fa_data != p_fad) || (fd_req && p_fd && fd_data != p_fdd)) stab_err++;
         if ((ia_req && p_ia && ia_data != p_iad) || (id_req && p_id && id_data != p_idd)) stab_err++;
         if (fd_req && !fa_req && p_fa) fa_early++;
         if (mem_rd && (|reqs[5:1] || |acks[5:1])) fetch_err++;
      end
      p_ls = ls_req; p_fa = fa_req; p_fd = fd_req; p_ts = ts_req;
      p_ia = ia_req; p_id = id_req; p_ld = ld_ack;
      p_fad = fa_data; p_fdd = fd_data; p_iad = ia_data; p_idd = id_data;
   end

   function automatic void load_seq1();
      exp_q.delete();
      exp_q.push_back(32'h0100_0000);
      exp_q.push_back(32'h0200_005A);
      exp_q.push_back(32'h0200_01C3);
      exp_q.push_back(32'h0300_0000);
      exp_q.push_back(32'h0400_0001);
      exp_q.push_back(32'h0400_0100);
      exp_q.push_back(32'h0400_0201);
      exp_q.push_back(32'h0500_0000);
      exp_q.push_back(32'h0300_0001);
      exp_q.push_back(32'h0400_0000);
      exp_q.push_back(32'h0400_0101);
      exp_q.push_back(32'h0400_0200);
      exp_q.push_back(32'h0500_0000);
      exp_q.push_back(32'h0600_0000);
   endfunction

   task automatic pulse_go();
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         #1;
         if (run_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, run_done, mem_rd, reqs, ld_ack} !== 10'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 0", {busy, run_done, mem_rd, reqs, ld_ack});
      end
      checks++;
      if ({mem_addr, fa_data, fd_data, ts_data, ia_data, id_data} !== 54'b0) begin
         errors++;
         $display("FAIL reset_data got %h exp 0", {mem_addr, fa_data, fd_data, ts_data, ia_data, id_data});
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({busy, reqs, ld_ack} !== 8'b0) begin
         errors++;
         $display("FAIL idle_after_reset got %b exp 0", {busy, reqs, ld_ack});
      end
   endtask

   task automatic test_basic();
      int base, d0;
      bit ok;
      load_seq1();
      base = obs_q.size();
      d0 = done_cnt;
      @(negedge clk);
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      checks++;
      if (busy !== 1'b1 || ls_req !== 1'b0) begin
         errors++;
         $display("FAIL basic_go_accept busy=%b ls_req=%b exp busy=1 ls_req=0", busy, ls_req);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ls_req !== 1'b1) begin
         errors++;
         $display("FAIL basic_ls_rise got %b exp 1", ls_req);
      end
      wait_done(1000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_timeout got no run_done exp run_done");
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_fall got %b exp 0", busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (run_done !== 1'b0 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL basic_done_pulse run_done=%b count=%0d exp 0 and 1", run_done, done_cnt - d0);
      end
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL basic_seq_len got %0d exp %0d", obs_q.size() - base, exp_q.size());
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (base + k >= obs_q.size() || obs_q[base + k] !== exp_q[k]) begin
            errors++;
            $display("FAIL basic_tok%0d got %h exp %h", k,
                     (base + k < obs_q.size()) ? obs_q[base + k] : 32'hxxxx_xxxx, exp_q[k]);
         end
      end
   endtask

   task automatic test_fd_delay();
      int base, fe0, se0, fx0;
      bit ok;
      load_seq1();
      base = obs_q.size();
      fe0 = fa_early; se0 = stab_err; fx0 = fetch_err;
      dly[2] = 5;
      pulse_go();
      wait_done(1000, ok);
      repeat (2) @(posedge clk);
      dly[2] = 0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fd_delay_timeout got no run_done exp run_done");
      end
      checks++;
      if (fa_early - fe0 != 2) begin
         errors++;
         $display("FAIL fd_delay_fa_early got %0d exp 2", fa_early - fe0);
      end
      checks++;
      if (stab_err != se0 || fetch_err != fx0) begin
         errors++;
         $display("FAIL fd_delay_hold stab=%0d fetch=%0d exp 0 0", stab_err - se0, fetch_err - fx0);
      end
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL fd_delay_seq_len got %0d exp %0d", obs_q.size() - base, exp_q.size());
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (base + k >= obs_q.size() || obs_q[base + k] !== exp_q[k]) begin
            errors++;
            $display("FAIL fd_delay_tok%0d got %h exp %h", k,
                     (base + k < obs_q.size()) ? obs_q[base + k] : 32'hxxxx_xxxx, exp_q[k]);
         end
      end
   endtask

   task automatic test_ld_early();
      int base, le0;
      bit ok, seen;
      load_seq1();
      base = obs_q.size();
      le0 = ld_err;
      ld_auto = 1'b0;
      ld_man = 1'b0;
      pulse_go();
      seen = 1'b0;
      for (int k = 0; k < 500 && !seen; k++) begin
         @(posedge clk);
         #1;
         seen = ia_req && (ia_data == 10'd1);
      end
      ld_man = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (!seen || ld_ack !== 1'b0) begin
         errors++;
         $display("FAIL ld_early_held seen=%b ld_ack=%b exp 1 0", seen, ld_ack);
      end
      seen = 1'b0;
      for (int k = 0; k < 500 && !seen; k++) begin
         @(posedge clk);
         #1;
         seen = ld_ack;
      end
      checks++;
      if (!seen || ia_req !== 1'b0 || id_req !== 1'b0 || ld_err != le0) begin
         errors++;
         $display("FAIL ld_early_ack seen=%b ia_req=%b id_req=%b err=%0d exp 1 0 0 0",
                  seen, ia_req, id_req, ld_err - le0);
      end
      ld_man = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 500 && !seen; k++) begin
         @(posedge clk);
         #1;
         seen = ts_req;
      end
      ld_auto = 1'b1;
      checks++;
      if (!seen || ts_data !== 4'd1) begin
         errors++;
         $display("FAIL ld_early_ts1 seen=%b ts_data=%0d exp 1 1", seen, ts_data);
      end
      wait_done(1000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ld_early_timeout got no run_done exp run_done");
      end
      @(posedge clk);
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL ld_early_seq_len got %0d exp %0d", obs_q.size() - base, exp_q.size());
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (base + k >= obs_q.size() || obs_q[base + k] !== exp_q[k]) begin
            errors++;
            $display("FAIL ld_early_tok%0d got %h exp %h", k,
                     (base + k < obs_q.size()) ? obs_q[base + k] : 32'hxxxx_xxxx, exp_q[k]);
         end
      end
   endtask

   task automatic test_go_ignored();
      int base, d0;
      bit ok, seen;
      load_seq1();
      base = obs_q.size();
      d0 = done_cnt;
      pulse_go();
      seen = 1'b0;
      for (int k = 0; k < 500 && !seen; k++) begin
         @(posedge clk);
         #1;
         seen = fa_req;
      end
      pulse_go();
      seen = 1'b0;
      for (int k = 0; k < 500 && !seen; k++) begin
         @(posedge clk);
         #1;
         seen = ia_req;
      end
      pulse_go();
      wait_done(1000, ok);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (!ok || done_cnt - d0 != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL go_ignored_done ok=%b count=%0d busy=%b exp 1 1 0", ok, done_cnt - d0, busy);
      end
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL go_ignored_seq_len got %0d exp %0d", obs_q.size() - base, exp_q.size());
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (base + k >= obs_q.size() || obs_q[base + k] !== exp_q[k]) begin
            errors++;
            $display("FAIL go_ignored_tok%0d got %h exp %h", k,
                     (base + k < obs_q.size()) ? obs_q[base + k] : 32'hxxxx_xxxx, exp_q[k]);
         end
      end
   endtask

   task automatic test_reset_restart();
      int base;
      bit ok, seen;
      load_seq1();
      pulse_go();
      seen = 1'b0;
      for (int k = 0; k < 500 && !seen; k++) begin
         @(posedge clk);
         #1;
         seen = fa_req;
      end
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (!seen || {reqs, ld_ack, busy, mem_rd} !== 9'b0) begin
         errors++;
         $display("FAIL reset_async seen=%b outs=%b exp 1 0", seen, {reqs, ld_ack, busy, mem_rd});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      base = obs_q.size();
      pulse_go();
      wait_done(1000, ok);
      @(posedge clk);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reset_restart_timeout got no run_done exp run_done");
      end
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL reset_restart_seq_len got %0d exp %0d", obs_q.size() - base, exp_q.size());
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (base + k >= obs_q.size() || obs_q[base + k] !== exp_q[k]) begin
            errors++;
            $display("FAIL reset_restart_tok%0d got %h exp %h", k,
                     (base + k < obs_q.size()) ? obs_q[base + k] : 32'hxxxx_xxxx, exp_q[k]);
         end
      end
   endtask

   task automatic test_protocol_flags();
      checks++;
      if (pair_err != 0 || stab_err != 0 || fetch_err != 0 || ld_err != 0) begin
         errors++;
         $display("FAIL protocol_flags pair=%0d stab=%0d fetch=%0d ld=%0d exp all 0",
                  pair_err, stab_err, fetch_err, ld_err);
      end
   endtask

   initial begin
      for (int c = 0; c < 6; c++) begin
         dly[c] = 0;
         cnt[c] = 0;
      end
      for (int a = 0; a < 16; a++) mem[a] = 8'h00;
      mem[0] = 8'h5A; mem[1] = 8'hC3; mem[2] = 8'h11; mem[3] = 8'h24;
      mem[4] = 8'h37; mem[5] = 8'h48; mem[6] = 8'h59; mem[7] = 8'h6E;
      test_reset();
      test_basic();
      test_fd_delay();
      test_ld_early();
      test_go_ignored();
      test_reset_restart();
      test_protocol_flags();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish exp finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/snn_load_tx.md
Name: snn_load_tx

Overview:
- Clocked host-side transmitter that sources the SNN_NoC load protocol.
- Reads filter weights and per-timestep input spikes from a synchronous source memory.
- Drives the load_start, filter_addr/filter_data, timestep and ifmap_addr/ifmap_data channels as 4-phase bundled-data senders.
- Acts as the receiver of the load_done token the NoC returns after each timestep's ifmap load.

Parameters:
- FILT_N, 25, number of filter words sent once per run.
- IFM_N, 625, number of ifmap words sent per timestep.
- NUM_TS, 10, number of timesteps per run.
- AW, 10, width of filter_addr/ifmap_addr buses; requires IFM_N ≤ 2^AW.
- DW, 8, data width of filter/ifmap words; ifmap uses bit 0 only, upper bits driven 0.
- MAW, 14, source-memory address width; requires FILT_N + NUM_TS*IFM_N ≤ 2^MAW.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- go, in, 1, one-cycle start pulse; ignored unless state is IDLE.
- busy, out, 1, high from go accepted until DONE.
- run_done, out, 1, one-cycle pulse on completion.
- mem_rd, out, 1, source-memory read strobe.
- mem_addr, out, MAW, source-memory address.
- mem_rdata, in, DW, read data, valid exactly 1 cycle after mem_rd.
- ls_req/ls_ack, out/in, 1/1, load_start channel; data is implicit (token only).
- fa_data/fa_req/fa_ack, out/out/in, AW/1/1, filter_addr channel.
- fd_data/fd_req/fd_ack, out/out/in, DW/1/1, filter_data channel.
- ts_data/ts_req/ts_ack, out/out/in, 4/1/1, timestep channel.
- ia_data/ia_req/ia_ack, out/out/in, AW/1/1, ifmap_addr channel.
- id_data/id_req/id_ack, out/out/in, DW/1/1, ifmap_data channel.
- ld_req/ld_ack, in/out, 1/1, load_done channel; this block is receiver.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-run aborts immediately and drops all req/ack outputs. Peers are re-reset together with this block.
- Send phase (every outbound channel):
  - Data registers are loaded in the cycle before req rises and held until ack falls.
  - req rises, then wait for ack=1, drop req, wait for ack=0; token complete.
  - Minimum 1 cycle of data setup before req.
- Paired channels (fa/fd, ia/id):
  - Both reqs rise in the same cycle.
  - Each req drops independently on its own ack.
  - The pair completes when both acks have returned to 0.
- Receive phase (ld):
  - On ld_req=1, raise ld_ack.
  - On ld_req=0, drop ld_ack.
  - Completion is on the falling edge.
- Memory map:
  - Filter word i is at address i.
  - Ifmap word j of timestep t is at address FILT_N + t*IFM_N + j.
  - Address arithmetic is a running counter, not a multiplier.
- Read timing:
  - mem_rd is issued in a FETCH state.
  - mem_rdata is captured the next cycle into fd_data/id_data.
  - Word prefetch during an outstanding handshake is not required.
- FSM:
  - IDLE: on go, go to LS_SEND.
  - LS_SEND: on token done, go to F_FETCH (i=0).
  - F_FETCH: go to F_CAP.
  - F_CAP: go to F_SEND.
  - F_SEND: on pair done, go to F_FETCH while i+1<FILT_N, else to TS_SEND (t=0).
  - TS_SEND: sends ts_data=t; on done, go to I_FETCH (j=0).
  - I_FETCH: go to I_CAP.
  - I_CAP: go to I_SEND.
  - I_SEND: on pair done, go to I_FETCH while j+1<IFM_N, else to LD_WAIT.
  - LD_WAIT: on ld handshake complete, go to TS_SEND with t+1 while t+1<NUM_TS, else to DONE.
  - DONE: pulses run_done for 1 cycle, then goes to IDLE.
- Address fields: fa_data=i and ia_data=j, zero-extended to AW.
- Boundary conditions:
  - go while busy: ignored.
  - ld_req asserted outside LD_WAIT: not acknowledged until LD_WAIT is reached.
  - ack=1 arriving while req is still 0: held off; req is not raised until the ack is observed low.
  - Counters never wrap within a run.
  - IFM_N=1 and NUM_TS=1 are legal.

Optional Feature:
- Macro: SNN_LOAD_TX_ACK_SYNC_EN.
- Defined:
  - Every inbound ack/req (ls_ack, fa_ack, fd_ack, ts_ack, ia_ack, id_ack, ld_req) passes through a 2-flop synchronizer reset to 0.
  - Each handshake edge gains 2 cycles of latency.
- Undefined:
  - Inbound signals are sampled directly on clk.
  - Only for same-domain simulation.

Test Plan:
- FILT_N=2, IFM_N=3, NUM_TS=2, immediate-responding peers, go pulse. Required response:
  - ls token first.
  - Filter pairs (0, mem[0]) and (1, mem[1]).
  - ts=0, then ifmap (0,mem[2]), (1,mem[3]), (2,mem[4]).
  - ld handshake, then ts=1 with ifmap words mem[5..7].
  - ld handshake, then run_done pulse exactly once, busy falls.
- fd_ack delayed 5 cycles relative to fa_ack -> fa_req drops early, but the FSM does not fetch word 1 until fd_ack is low; fd_data is stable while fd_req=1.
- ld_req pulsed during I_SEND of word 1 and held -> ld_ack stays 0 until LD_WAIT, then the handshake completes and ts=1 is sent.
- go asserted again mid-run -> no restart; sequence and counters are unaffected.
- reset asserted while fa_req=1 in F_SEND -> all reqs and busy go 0 asynchronously. A following go restarts from the ls token with i=0.
- With SNN_LOAD_TX_ACK_SYNC_EN defined -> identical token order and data as scenario 1; each handshake takes +4 cycles versus undefined.
